// File: rtl/div_if.sv
// Handshake and operand/result bundle between the E-stage pipeline and the
// iterative divide sequencer.
interface div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             stall_ext;
    logic             stall;
    logic             ready;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, signed_div, a, b, cancel, stall_ext,
        input  stall, ready, hi, lo
    );

    modport slave (
        input  start, signed_div, a, b, cancel, stall_ext,
        output stall, ready, hi, lo
    );
endinterface

// File: rtl/div_ctrl.sv
// Iterative restoring divide sequencer for DIV/DIVU in the execute stage.
// Holds the pipeline while busy and presents {hi, lo} = {remainder, quotient}.
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // One restoring step: bit WIDTH of the trial subtraction is the borrow.
    always_comb begin
        a_abs    = (bus.signed_div && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
        b_abs    = (bus.signed_div && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
        trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        rem_next = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
        quo_next = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.b == '0) begin
                        hi_d    = bus.a;
                        lo_d    = '1;
                        state_d = DONE;
                    end else begin
                        dvs_d   = b_abs;
                        quo_d   = a_abs;
                        rem_d   = '0;
                        cnt_d   = '0;
                        qneg_d  = bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        rneg_d  = bus.signed_div & bus.a[WIDTH-1];
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                rem_d = rem_next;
                quo_d = quo_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) begin
                    hi_d    = rneg_q ? (~rem_next + 1'b1) : rem_next;
                    lo_d    = qneg_q ? (~quo_next + 1'b1) : quo_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                // start is deliberately ignored here so the retiring DIV cannot relaunch
                if (!bus.stall_ext) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A flush wins over everything and must never disturb the HI/LO result.
        if (bus.cancel) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign bus.ready = (state_q == DONE);
    assign bus.stall = rst & ~bus.cancel & (((state_q == IDLE) & bus.start) | (state_q == BUSY));
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule
